// File: rtl/semaforo_pkg.sv
// Shared definitions for the intersection controller: state codes and light encodings.
package semaforo_pkg;

  typedef enum logic [3:0] {
    NS_VERDE    = 4'd0,
    NS_AMARILLO = 4'd1,
    ROJO_A      = 4'd2,
    EO_VERDE    = 4'd3,
    EO_AMARILLO = 4'd4,
    ROJO_B      = 4'd5,
    PEATON      = 4'd6,
    OFF_A       = 4'd7,
    ONALL       = 4'd8
  } estado_t;

  localparam logic [2:0] LUZ_VERDE    = 3'b100;
  localparam logic [2:0] LUZ_AMARILLO = 3'b010;
  localparam logic [2:0] LUZ_ROJO     = 3'b001;
  localparam logic [2:0] LUZ_OFF      = 3'b000;
  localparam logic [2:0] LUZ_ALL      = 3'b111;

endpackage

// File: rtl/temporizador_fase.sv
// Loadable phase down-counter; expired flags a tick arriving while the count is zero.
module temporizador_fase #(
  parameter int unsigned   TW      = 8,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic          expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt <= RST_VAL;
    else if (load)                cnt <= load_val;
    else if (tick && cnt != '0)   cnt <= cnt - TW'(1);
  end

  assign expired = tick && (cnt == '0);

endmodule

// File: rtl/interseccion_ctrl.sv
// Two-way intersection sequencer with blink fallback.
// Define PEATON_EN to enable the pedestrian all-red walk phase.
module interseccion_ctrl
  import semaforo_pkg::*;
#(
  parameter int unsigned TW         = 8,
  parameter int unsigned T_VERDE    = 20,
  parameter int unsigned T_AMARILLO = 4,
  parameter int unsigned T_ROJO     = 2,
  parameter int unsigned T_PEATON   = 10,
  parameter int unsigned T_BLINK    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       on_off,
  input  logic       ped_req,
  output logic [2:0] luz_ns,
  output logic [2:0] luz_eo,
  output logic       ped_walk,
  output logic [3:0] fase
);

  estado_t       estado, estado_sig;
  logic          expired, load;
  logic [TW-1:0] load_val;

`ifdef PEATON_EN
  logic pendiente, pendiente_sig;

  // A request in the same cycle ROJO_B expires is honoured immediately.
  always_comb begin
    pendiente_sig = 1'b0;
    case (estado)
      NS_VERDE, NS_AMARILLO, ROJO_A, EO_VERDE, EO_AMARILLO, ROJO_B:
        pendiente_sig = pendiente | ped_req;
      default: pendiente_sig = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pendiente <= 1'b0;
    else       pendiente <= pendiente_sig;
  end
`else
  logic ped_req_unused;
  assign ped_req_unused = ped_req;
`endif

  always_comb begin
    estado_sig = estado;
    case (estado)
      NS_VERDE:    if (!on_off) estado_sig = OFF_A; else if (expired) estado_sig = NS_AMARILLO;
      NS_AMARILLO: if (!on_off) estado_sig = OFF_A; else if (expired) estado_sig = ROJO_A;
      ROJO_A:      if (!on_off) estado_sig = OFF_A; else if (expired) estado_sig = EO_VERDE;
      EO_VERDE:    if (!on_off) estado_sig = OFF_A; else if (expired) estado_sig = EO_AMARILLO;
      EO_AMARILLO: if (!on_off) estado_sig = OFF_A; else if (expired) estado_sig = ROJO_B;
      ROJO_B: begin
        if (!on_off) estado_sig = OFF_A;
        else if (expired) begin
`ifdef PEATON_EN
          estado_sig = pendiente_sig ? PEATON : NS_VERDE;
`else
          estado_sig = NS_VERDE;
`endif
        end
      end
`ifdef PEATON_EN
      PEATON:      if (!on_off) estado_sig = OFF_A; else if (expired) estado_sig = NS_VERDE;
`endif
      OFF_A:       if (on_off) estado_sig = ROJO_B; else if (expired) estado_sig = ONALL;
      ONALL:       if (on_off) estado_sig = ROJO_B; else if (expired) estado_sig = OFF_A;
      default:     estado_sig = OFF_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= ROJO_B;
    else       estado <= estado_sig;
  end

  // Every state change reloads the timer with the new phase length minus one.
  assign load = (estado_sig != estado);

  always_comb begin
    load_val = '0;
    case (estado_sig)
      NS_VERDE, EO_VERDE:       load_val = TW'(T_VERDE - 1);
      NS_AMARILLO, EO_AMARILLO: load_val = TW'(T_AMARILLO - 1);
      ROJO_A, ROJO_B:           load_val = TW'(T_ROJO - 1);
      PEATON:                   load_val = TW'(T_PEATON - 1);
      OFF_A, ONALL:             load_val = TW'(T_BLINK - 1);
      default:                  load_val = '0;
    endcase
  end

  temporizador_fase #(
    .TW      (TW),
    .RST_VAL (TW'(T_ROJO - 1))
  ) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .expired  (expired)
  );

  always_comb begin
    luz_ns = LUZ_ROJO;
    luz_eo = LUZ_ROJO;
    case (estado)
      NS_VERDE:    luz_ns = LUZ_VERDE;
      NS_AMARILLO: luz_ns = LUZ_AMARILLO;
      EO_VERDE:    luz_eo = LUZ_VERDE;
      EO_AMARILLO: luz_eo = LUZ_AMARILLO;
      ROJO_A, ROJO_B: begin
        luz_ns = LUZ_ROJO;
        luz_eo = LUZ_ROJO;
      end
`ifdef PEATON_EN
      PEATON: begin
        luz_ns = LUZ_ROJO;
        luz_eo = LUZ_ROJO;
      end
`endif
      OFF_A: begin
        luz_ns = LUZ_OFF;
        luz_eo = LUZ_OFF;
      end
      default: begin
        luz_ns = LUZ_ALL;
        luz_eo = LUZ_ALL;
      end
    endcase
  end

`ifdef PEATON_EN
  assign ped_walk = (estado == PEATON);
`else
  assign ped_walk = 1'b0;
`endif

  assign fase = estado;

endmodule

// File: tb/tb_interseccion_ctrl.sv
// Scoreboard bench for interseccion_ctrl: directed phase sequences, blink, reset and pedestrian cases.
module tb_interseccion_ctrl;
  import semaforo_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic       on_off = 1'b1;
  logic       ped_req = 1'b0;
  logic [2:0] luz_ns, luz_eo;
  logic       ped_walk;
  logic [3:0] fase;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tick_cnt = 0;
  int unsigned tick_div = 1;
  logic [10:0] exp_q[$];

  interseccion_ctrl #(
    .TW         (8),
    .T_VERDE    (3),
    .T_AMARILLO (2),
    .T_ROJO     (1),
    .T_PEATON   (2),
    .T_BLINK    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .on_off   (on_off),
    .ped_req  (ped_req),
    .luz_ns   (luz_ns),
    .luz_eo   (luz_eo),
    .ped_walk (ped_walk),
    .fase     (fase)
  );

  always #5 clk = ~clk;

  // Expected {fase, ns, eo, walk} for a given state, straight from the light table.
  function automatic logic [10:0] exp_of(input estado_t s);
    logic [2:0] ns, eo;
    logic w;
    ns = 3'b001; eo = 3'b001; w = 1'b0;
    case (s)
      NS_VERDE:    ns = 3'b100;
      NS_AMARILLO: ns = 3'b010;
      EO_VERDE:    eo = 3'b100;
      EO_AMARILLO: eo = 3'b010;
      PEATON:      w = 1'b1;
      OFF_A:       begin ns = 3'b000; eo = 3'b000; end
      ONALL:       begin ns = 3'b111; eo = 3'b111; end
      default:     ;
    endcase
    return {s, ns, eo, w};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input estado_t s, input logic on, input logic ped);
    @(negedge clk);
    reset   = 1'b0;
    on_off  = on;
    ped_req = ped;
    tick    = (tick_div <= 1) ? 1'b1 : ((tick_cnt % tick_div) == 0);
    tick_cnt++;
    exp_q.push_back(exp_of(s));
    @(posedge clk);
  endtask

  task automatic run(input estado_t s, input int unsigned n, input logic on, input logic ped);
    repeat (n) step(s, on, ped);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; on_off = 1'b1; ped_req = 1'b0; tick = 1'b1;
    tick_cnt = 0; tick_div = 1;
    @(posedge clk);
    #1 check("reset_state", 32'({fase, luz_ns, luz_eo, ped_walk}), 32'(exp_of(ROJO_B)));
  endtask

  // Monitor: one expectation per clock once stimulus is running, plus the safety invariant.
  always @(posedge clk) begin
    logic [10:0] e;
    #1;
    check("no_dual_green", 32'(luz_ns == 3'b100 && luz_eo == 3'b100), 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("phase_out", 32'({fase, luz_ns, luz_eo, ped_walk}), 32'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Free-running cycle with tick tied high.
    do_reset();
    run(NS_VERDE, 3, 1, 0); run(NS_AMARILLO, 2, 1, 0); run(ROJO_A, 1, 1, 0);
    run(EO_VERDE, 3, 1, 0); run(EO_AMARILLO, 2, 1, 0); run(ROJO_B, 1, 1, 0);
    run(NS_VERDE, 3, 1, 0); run(NS_AMARILLO, 1, 1, 0);

    // tick one cycle in four: every phase stretches fourfold.
    do_reset();
    tick_div = 4;
    run(NS_VERDE, 12, 1, 0); run(NS_AMARILLO, 8, 1, 0); run(ROJO_A, 4, 1, 0);
    run(EO_VERDE, 12, 1, 0); run(EO_AMARILLO, 8, 1, 0); run(ROJO_B, 4, 1, 0);
    run(NS_VERDE, 4, 1, 0);
    tick_div = 1;

`ifdef PEATON_EN
    // Request during green, request during walk, request on the ROJO_B expiry cycle.
    do_reset();
    step(NS_VERDE, 1, 0); step(NS_VERDE, 1, 1); step(NS_VERDE, 1, 0);
    run(NS_AMARILLO, 2, 1, 0); run(ROJO_A, 1, 1, 0); run(EO_VERDE, 3, 1, 0);
    run(EO_AMARILLO, 2, 1, 0); run(ROJO_B, 1, 1, 0);
    step(PEATON, 1, 0); step(PEATON, 1, 1); step(NS_VERDE, 1, 1);
    run(NS_VERDE, 2, 1, 0); run(NS_AMARILLO, 2, 1, 0); run(ROJO_A, 1, 1, 0);
    run(EO_VERDE, 3, 1, 0); run(EO_AMARILLO, 2, 1, 0); run(ROJO_B, 1, 1, 0);
    run(NS_VERDE, 3, 1, 0); run(NS_AMARILLO, 2, 1, 0); run(ROJO_A, 1, 1, 0);
    run(EO_VERDE, 3, 1, 0); run(EO_AMARILLO, 2, 1, 0); run(ROJO_B, 1, 1, 0);
    step(PEATON, 1, 1); step(PEATON, 1, 0); step(NS_VERDE, 1, 0);
`else
    // Without the walk phase a held request changes nothing.
    do_reset();
    run(NS_VERDE, 3, 1, 1); run(NS_AMARILLO, 2, 1, 1); run(ROJO_A, 1, 1, 1);
    run(EO_VERDE, 3, 1, 1); run(EO_AMARILLO, 2, 1, 1); run(ROJO_B, 1, 1, 1);
    run(NS_VERDE, 3, 1, 1); run(NS_AMARILLO, 1, 1, 1);
`endif

    // Out of service during EO green, blink, recovery, then on_off beating an expiry.
    do_reset();
    run(NS_VERDE, 3, 1, 0); run(NS_AMARILLO, 2, 1, 0); run(ROJO_A, 1, 1, 0);
    run(EO_VERDE, 1, 1, 0);
    run(OFF_A, 2, 0, 0); run(ONALL, 2, 0, 0); run(OFF_A, 2, 0, 0); run(ONALL, 1, 0, 0);
    step(ROJO_B, 1, 0); run(NS_VERDE, 3, 1, 0);
    step(OFF_A, 0, 0); step(OFF_A, 0, 0);
    step(ROJO_B, 1, 0); step(NS_VERDE, 1, 0);

    // Asynchronous reset in the middle of NS yellow.
    do_reset();
    run(NS_VERDE, 3, 1, 0); run(NS_AMARILLO, 1, 1, 0);
    #3 reset = 1'b1;
    #1 check("async_reset", 32'({fase, luz_ns, luz_eo, ped_walk}), 32'(exp_of(ROJO_B)));
    step(NS_VERDE, 1, 0); run(NS_VERDE, 2, 1, 0); run(NS_AMARILLO, 2, 1, 0);

    @(posedge clk);
    #2 check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
